// File: rtl/usr_io_bridge.sv
// rtl/usr_io_bridge.sv - board/debug user I/O conditioning bridge (sync, mux, debounce, press pulse, LED regs)
//
// Purpose: synchronizes raw key/switch inputs from either the board pins or the
// debug tool, debounces them, generates one-cycle key press pulses and registers
// LED requests towards the pins and the debug-tool mirror.
//
// Ports:
//   fpga_clk_50            sole clock
//   rst                    asynchronous active-high reset
//   src_sel                input source select (0 = board pins, 1 = debug tool)
//   board_key_i/board_sw_i raw board keys (active-low) / switches
//   dbg_key_i/dbg_sw_i     debug-tool keys / switches
//   usr_key_o/usr_sw_o     conditioned keys / switches
//   key_press_o            one-cycle pulse per key press (stable 1->0)
//   usr_led_i              LED request from the student module
//   led_o/dbg_led_o        registered LED drive / debug mirror
//
// Configuration macro: USR_IO_DEBOUNCE_EN
//   defined   - per-channel debounce counters, pin-to-output latency 2 + DEB_CYCLES
//   undefined - no counters, stable registers follow the sample, latency 3
module usr_io_bridge #(
   parameter int N_KEY      = 3,
   parameter int N_SW       = 3,
   parameter int N_LED      = 10,
   parameter int DEB_CYCLES = 500000
) (
   input  logic             fpga_clk_50,
   input  logic             rst,
   input  logic             src_sel,
   input  logic [N_KEY-1:0] board_key_i,
   input  logic [N_SW-1:0]  board_sw_i,
   input  logic [N_KEY-1:0] dbg_key_i,
   input  logic [N_SW-1:0]  dbg_sw_i,
   output logic [N_KEY-1:0] usr_key_o,
   output logic [N_SW-1:0]  usr_sw_o,
   output logic [N_KEY-1:0] key_press_o,
   input  logic [N_LED-1:0] usr_led_i,
   output logic [N_LED-1:0] led_o,
   output logic [N_LED-1:0] dbg_led_o
);

   // Keys and switches are handled as one vector: keys in the low bits.
   localparam int NI = N_KEY + N_SW;
   localparam logic [NI-1:0] IN_RST = {{N_SW{1'b0}}, {N_KEY{1'b1}}};

   if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << 24)) begin : g_bad_deb
      $error("usr_io_bridge: DEB_CYCLES out of range 2..2^24");
   end

   logic              sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
   logic [NI-1:0]     brd_s1_q, brd_s1_d, brd_s2_q, brd_s2_d;
   logic [NI-1:0]     dbg_s1_q, dbg_s1_d, dbg_s2_q, dbg_s2_d;
   logic [NI-1:0]     st_q, st_d;
   logic [N_KEY-1:0]  key_prev_q, key_prev_d;
   logic [N_KEY-1:0]  press_q, press_d;
   logic [N_LED-1:0]  led_q, led_d;
   logic [NI-1:0]     sample;

`ifdef USR_IO_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   logic [CW-1:0]     cnt_q [NI];
   logic [CW-1:0]     cnt_d [NI];
   logic              sel_chg;
`endif

   always_comb begin
      sel_s1_d   = src_sel;
      sel_s2_d   = sel_s1_q;
      brd_s1_d   = {board_sw_i, board_key_i};
      brd_s2_d   = brd_s1_q;
      dbg_s1_d   = {dbg_sw_i, dbg_key_i};
      dbg_s2_d   = dbg_s1_q;
      sample     = sel_s2_q ? dbg_s2_q : brd_s2_q;
      st_d       = st_q;
      key_prev_d = st_q[N_KEY-1:0];
      // prev still holds the old stable value in the cycle after the fall,
      // so the registered pulse lands one cycle after usr_key_o drops.
      press_d    = key_prev_q & ~st_q[N_KEY-1:0];
      led_d      = usr_led_i;
`ifdef USR_IO_DEBOUNCE_EN
      // True in the cycle whose closing edge updates the synchronized select,
      // so every window restarts together with the source swap.
      sel_chg    = sel_s1_q ^ sel_s2_q;
      for (int i = 0; i < NI; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sel_chg || (sample[i] == st_q[i])) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            st_d[i]  = sample[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
`else
      st_d       = sample;
`endif
   end

   always_ff @(posedge fpga_clk_50 or posedge rst) begin
      if (rst) begin
         sel_s1_q   <= 1'b0;
         sel_s2_q   <= 1'b0;
         brd_s1_q   <= IN_RST;
         brd_s2_q   <= IN_RST;
         dbg_s1_q   <= IN_RST;
         dbg_s2_q   <= IN_RST;
         st_q       <= IN_RST;
         key_prev_q <= {N_KEY{1'b1}};
         press_q    <= '0;
         led_q      <= '0;
`ifdef USR_IO_DEBOUNCE_EN
         for (int i = 0; i < NI; i++) cnt_q[i] <= '0;
`endif
      end else begin
         sel_s1_q   <= sel_s1_d;
         sel_s2_q   <= sel_s2_d;
         brd_s1_q   <= brd_s1_d;
         brd_s2_q   <= brd_s2_d;
         dbg_s1_q   <= dbg_s1_d;
         dbg_s2_q   <= dbg_s2_d;
         st_q       <= st_d;
         key_prev_q <= key_prev_d;
         press_q    <= press_d;
         led_q      <= led_d;
`ifdef USR_IO_DEBOUNCE_EN
         for (int i = 0; i < NI; i++) cnt_q[i] <= cnt_d[i];
`endif
      end
   end

   assign usr_key_o   = st_q[N_KEY-1:0];
   assign usr_sw_o    = st_q[NI-1:N_KEY];
   assign key_press_o = press_q;
   assign led_o       = led_q;
   assign dbg_led_o   = led_q;

endmodule

// File: tb/tb_usr_io_bridge.sv
// tb/tb_usr_io_bridge.sv - directed self-checking bench for usr_io_bridge
module tb_usr_io_bridge;

   localparam int DEB = 4;
`ifdef USR_IO_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 3;
`endif

   logic        clk;
   logic        rst;
   logic        src_sel;
   logic [2:0]  board_key_i, board_sw_i, dbg_key_i, dbg_sw_i;
   logic [2:0]  usr_key_o, usr_sw_o, key_press_o;
   logic [9:0]  usr_led_i, led_o, dbg_led_o;

   int tests = 0;
   int fails = 0;

   usr_io_bridge #(
      .N_KEY(3), .N_SW(3), .N_LED(10), .DEB_CYCLES(DEB)
   ) dut (
      .fpga_clk_50 (clk),
      .rst         (rst),
      .src_sel     (src_sel),
      .board_key_i (board_key_i),
      .board_sw_i  (board_sw_i),
      .dbg_key_i   (dbg_key_i),
      .dbg_sw_i    (dbg_sw_i),
      .usr_key_o   (usr_key_o),
      .usr_sw_o    (usr_sw_o),
      .key_press_o (key_press_o),
      .usr_led_i   (usr_led_i),
      .led_o       (led_o),
      .dbg_led_o   (dbg_led_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst = 1'b0; src_sel = 1'b0;
      board_key_i = 3'b111; board_sw_i = 3'b000;
      dbg_key_i = 3'b111;   dbg_sw_i = 3'b000;
      usr_led_i = 10'h000;
      #3 rst = 1'b1;
      #1;
      // asynchronous reset values, before any clock edge
      chk("rst_key",   usr_key_o,   3'b111);
      chk("rst_sw",    usr_sw_o,    3'b000);
      chk("rst_press", key_press_o, 3'b000);
      chk("rst_led",   led_o,       10'h000);
      chk("rst_dled",  dbg_led_o,   10'h000);
      repeat (3) tick();
      rst = 1'b0;

      // idle after release
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("idle_key",   usr_key_o,   3'b111);
         chk("idle_press", key_press_o, 3'b000);
         chk("idle_led",   led_o,       10'h000);
      end

      // key 0 press: falls LAT clocks after the change, pulse the cycle after
      board_key_i = 3'b110;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("k0_key",   usr_key_o,   (k >= LAT) ? 3'b110 : 3'b111);
         chk("k0_press", key_press_o, (k == LAT + 1) ? 3'b001 : 3'b000);
      end
      // release gives no pulse
      board_key_i = 3'b111;
      for (int k = 1; k <= LAT + 2; k++) begin
         tick();
         chk("k0_rel_press", key_press_o, 3'b000);
      end
      chk("k0_rel_key", usr_key_o, 3'b111);

`ifdef USR_IO_DEBOUNCE_EN
      // 3-clock glitch on switch 1 is filtered
      board_sw_i = 3'b010;
      repeat (3) begin
         tick();
         chk("glitch_sw", usr_sw_o, 3'b000);
      end
      board_sw_i = 3'b000;
      repeat (6) begin
         tick();
         chk("glitch_sw", usr_sw_o, 3'b000);
         chk("glitch_press", key_press_o, 3'b000);
      end
`endif

      // debug-tool source
      src_sel = 1'b1; dbg_sw_i = 3'b101;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         chk("dbg_sw", usr_sw_o, (k >= LAT) ? 3'b101 : 3'b000);
      end

`ifdef USR_IO_DEBOUNCE_EN
      // src_sel toggle mid-window restarts the count
      dbg_sw_i = 3'b010; board_sw_i = 3'b010;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("restart_sw", usr_sw_o, (k >= 10) ? 3'b010 : 3'b101);
         chk("restart_press", key_press_o, 3'b000);
         if (k == 4) src_sel = 1'b0;
      end
`else
      dbg_sw_i = 3'b010; board_sw_i = 3'b010; src_sel = 1'b0;
      repeat (4) tick();
      chk("sel_back_sw", usr_sw_o, 3'b010);
`endif

      // LED path: one clock delay
      usr_led_i = 10'h2A5;
      chk("led_before", led_o, 10'h000);
      tick();
      chk("led_o",   led_o,     10'h2A5);
      chk("dbg_led", dbg_led_o, 10'h2A5);
      usr_led_i = 10'h15A;
      tick();
      chk("led_o2",   led_o,     10'h15A);
      chk("dbg_led2", dbg_led_o, 10'h15A);

      // reset in the middle of a key 1 press window
      board_key_i = 3'b101;
      repeat (LAT - 2) tick();
      chk("pre_rst_key", usr_key_o, 3'b111);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_key",   usr_key_o,   3'b111);
      chk("mid_rst_sw",    usr_sw_o,    3'b000);
      chk("mid_rst_press", key_press_o, 3'b000);
      chk("mid_rst_led",   led_o,       10'h000);
      chk("mid_rst_dled",  dbg_led_o,   10'h000);
      board_key_i = 3'b111;
      repeat (2) tick();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("post_rst_press", key_press_o, 3'b000);
         chk("post_rst_key",   usr_key_o,   3'b111);
      end

`ifndef USR_IO_DEBOUNCE_EN
      // without debounce: key 2 low 3 clocks later, pulse follows
      board_key_i = 3'b011;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("nodeb_key",   usr_key_o,   (k >= 3) ? 3'b011 : 3'b111);
         chk("nodeb_press", key_press_o, (k == 4) ? 3'b100 : 3'b000);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/usr_io_bridge.md
USR_IO_BRIDGE -- requirements
Module: usr_io_bridge

Interface
REQ-001 SHALL have parameter N_KEY, default 3: number of key channels (active-low).
REQ-002 SHALL have parameter N_SW, default 3: number of switch channels.
REQ-003 SHALL have parameter N_LED, default 10: number of LED channels (active-high).
REQ-004 SHALL have parameter DEB_CYCLES, default 500000: debounce stability window in clocks (10 ms at 50 MHz), legal range 2..2^24.
REQ-005 SHALL have port fpga_clk_50, input, 1: sole clock.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port src_sel, input, 1: input source select (0 = board pins, 1 = debug tool).
REQ-008 SHALL have port board_key_i, input, N_KEY: raw board keys.
REQ-009 SHALL have port board_sw_i, input, N_SW: raw board switches.
REQ-010 SHALL have port dbg_key_i, input, N_KEY: debug-tool keys.
REQ-011 SHALL have port dbg_sw_i, input, N_SW: debug-tool switches.
REQ-012 SHALL have port usr_key_o, output, N_KEY: conditioned keys to the student module.
REQ-013 SHALL have port usr_sw_o, output, N_SW: conditioned switches to the student module.
REQ-014 SHALL have port key_press_o, output, N_KEY: one-cycle pulse per press.
REQ-015 SHALL have port usr_led_i, input, N_LED: LED request from the student module.
REQ-016 SHALL have port led_o, output, N_LED: registered LED drive to pins.
REQ-017 SHALL have port dbg_led_o, output, N_LED: registered LED mirror to the debug tool.

Function
REQ-018 Every input bit (src_sel and all key/switch sources) SHALL pass a 2-flop synchronizer before use.
REQ-019 The synchronized src_sel SHALL select board or debug inputs per channel via a multiplexer feeding the debounce stage.
REQ-020 Each channel SHALL hold a stable register and a counter of width clog2(DEB_CYCLES).
REQ-021 The counter SHALL clear in any cycle where the sampled value equals stable, and increment otherwise.
REQ-022 When the counter equals DEB_CYCLES-1 and the sample still differs, stable SHALL take the sample and the counter SHALL clear, so stable changes after exactly DEB_CYCLES consecutive differing samples.
REQ-023 A glitch shorter than DEB_CYCLES clocks SHALL never change stable; the counter SHALL NOT wrap.
REQ-024 usr_key_o and usr_sw_o SHALL equal the key and switch stable registers.
REQ-025 key_press_o[i] SHALL be high for exactly one cycle, the cycle after stable key i goes 1->0; a 0->1 transition SHALL produce no pulse.
REQ-026 A change of synchronized src_sel SHALL clear all debounce counters in that cycle while stable values hold, and SHALL generate no press pulse by itself.
REQ-027 led_o and dbg_led_o SHALL both equal usr_led_i delayed by one clock.
REQ-028 Input-pin-to-usr_key_o/usr_sw_o latency SHALL be 2 + DEB_CYCLES clocks.

Reset
REQ-029 On rst assertion, outputs SHALL immediately take these values: usr_key_o all 1s, usr_sw_o 0, key_press_o 0, led_o 0, dbg_led_o 0.
REQ-030 On rst assertion, synchronizers SHALL reset to these values: key 1, switch 0, src_sel 0; counters SHALL reset to 0.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count, and no pulse SHALL be emitted on release.
REQ-032 After rst deassertion, operation SHALL begin on the next rising edge.

Configuration
REQ-033 Macro USR_IO_DEBOUNCE_EN defined: debounce per REQ-020..REQ-023, latency 2 + DEB_CYCLES.
REQ-034 Macro USR_IO_DEBOUNCE_EN undefined: no counters are built, stable registers load the muxed synchronized sample every cycle, latency is 3 clocks, and DEB_CYCLES is ignored; all other behaviour is unchanged.

Verification (DEB_CYCLES=4, N_KEY=3, N_SW=3, N_LED=10, USR_IO_DEBOUNCE_EN defined unless noted)
REQ-035 Reset, then release with src_sel=0 and board_key_i=3'b111 -> usr_key_o=3'b111, key_press_o=0, led_o=0 throughout.
REQ-036 board_key_i[0] to 0 held 10 clocks -> usr_key_o[0] falls 6 clocks after the change, and key_press_o=3'b001 for exactly one cycle, the cycle after that.
REQ-037 board_sw_i[1] pulsed high for 3 clocks -> usr_sw_o stays 3'b000, no pulse.
REQ-038 src_sel=1, dbg_sw_i=3'b101 held -> usr_sw_o=3'b101 after 6 clocks; toggling src_sel mid-count restarts the window.
REQ-039 usr_led_i=10'h2A5 -> led_o=dbg_led_o=10'h2A5 one clock later; rst asserted mid-press-count -> outputs at reset values, no pulse after release.
REQ-040 USR_IO_DEBOUNCE_EN undefined: board_key_i[2] to 0 -> usr_key_o[2] low 3 clocks later, press pulse follows.
